dmem_ctrl: RTL
==============

# dmem_ctrl

Data-memory controller sitting directly downstream of the load/store unit. It consumes the LSU's valid/ready data-memory request (byte address, byte-lane write enables, lane-aligned write data) and drives a single-port synchronous SRAM with one-cycle read latency. It returns lane-aligned read data and a one-cycle `ready` pulse per request, with optional wait-state insertion. Byte extraction and sign extension stay in the LSU.

## Interface
Parameters:
- `MEM_DEPTH_WORDS`, default 262144: SRAM depth in 32-bit words; power of two; 262144 covers the 1 MiB data space.
- `WAIT_STATES`, default 0: extra idle cycles inserted before each SRAM access; 0 to 15.
- `AW`, default `$clog2(MEM_DEPTH_WORDS)`: SRAM word-address width, derived from `MEM_DEPTH_WORDS`.

Ports (clock is `clk`, reset is `rst_n`; one clock; reset asynchronous, active-low):
- `clk  in  1`  clock
- `rst_n  in  1`  asynchronous active-low reset
- `dmem_valid_i  in  1`  request present
- `dmem_ready_o  out  1`  one-cycle completion pulse
- `dmem_addr_i  in  32`  byte address
- `dmem_wdata_i  in  32`  lane-aligned write data
- `dmem_we_i  in  4`  byte write enables; 0 means read
- `dmem_rdata_o  out  32`  read data, valid only while `dmem_ready_o` is 1
- `dmem_err_o  out  1`  out-of-range flag, valid only with `dmem_ready_o`
- `sram_cs_o  out  1`  SRAM chip select
- `sram_we_o  out  4`  SRAM byte write enables
- `sram_addr_o  out  AW`  SRAM word address
- `sram_wdata_o  out  32`  SRAM write data
- `sram_rdata_i  in  32`  SRAM read data, valid the cycle after a read select

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE with `dmem_valid_i` = 1 (acceptance):
  - latches addr, we and wdata;
  - goes to WAIT if `WAIT_STATES` > 0, else to ACCESS.
- WAIT: a 4-bit counter loads `WAIT_STATES`-1 on entry and decrements each cycle; at 0 the FSM goes to ACCESS.
- ACCESS:
  - `sram_cs_o` = 1, driven from the latched request;
  - `sram_addr_o` = latched addr[AW+1:2];
  - `sram_we_o` = latched we;
  - next state is RESP.
- RESP:
  - `dmem_ready_o` = 1;
  - `dmem_rdata_o` = `sram_rdata_i` for reads, 0 for writes;
  - next state is IDLE.
- Out of range means any of addr[31:AW+2] is set:
  - `sram_cs_o` is held 0 in ACCESS, so writes are dropped;
  - reads return 0;
  - `dmem_err_o` = 1 in RESP.
- `dmem_we_i` is forwarded unmodified; lane decoding and misalignment detection belong to the LSU.
- A request is captured at acceptance. Dropping `dmem_valid_i` afterwards does not cancel it; the `ready` pulse is still produced.
- The master holds its request until `ready`. In the cycle after `ready` the FSM is in IDLE, so back-to-back requests are accepted with no bubble beyond the FSM latency.

## Timing
- Reset values:
  - FSM = IDLE, wait counter = 0;
  - `dmem_ready_o`, `dmem_err_o`, `sram_cs_o` = 0;
  - `sram_we_o` = 0;
  - `dmem_rdata_o`, `sram_addr_o`, `sram_wdata_o` = 0.
- Read, W = `WAIT_STATES`: accepted in cycle 0, ACCESS in cycle 1+W, ready in cycle 2+W.
- Write (non-posted): same latency, ready in cycle 2+W.
- `sram_cs_o` and `sram_we_o` come from registers. They are never combinational from `dmem_*_i`.
- Reset asserted mid-transaction:
  - FSM returns to IDLE at once and `sram_cs_o` drops asynchronously;
  - no ready pulse is produced; a pending write is discarded.
- A valid request arriving in any state other than IDLE is not accepted until IDLE.

## Configuration
- `DMEM_POSTED_WRITE_EN` defined:
  - a write accepted in IDLE gets `dmem_ready_o` = 1 in the same cycle (0-cycle write latency), with `dmem_err_o` set if out of range;
  - the write is then performed through WAIT/ACCESS and returns to IDLE without entering RESP;
  - `dmem_ready_o` stays 0 during the drain, so a following read stalls, which preserves read-after-write order;
  - reads are unchanged.
- Not defined: writes follow the non-posted timing above.

## Structure
- Shared package `dmem_pkg`:
  - `dmem_state_t` enum (IDLE, WAIT, ACCESS, RESP);
  - `DMEM_WORD_BYTES` = 4;
  - `DMEM_MAX_WAIT` = 15.
- One natural sub-module: `dmem_wait_cnt`, a loadable 4-bit down-counter with a `zero` output used by the WAIT state.

## Test plan
- Read, W=0:
  - stimulus: SRAM word 0x10 preloaded with 0xDEADBEEF; valid, addr 0x40, we 0;
  - response: `sram_cs_o` in cycle 1 with addr 0x10; ready in cycle 2 with rdata 0xDEADBEEF and err 0.
- Byte write, W=3: addr 0x41, we 4'b0010, wdata 0x0000AB00 -> ACCESS in cycle 4, ready in cycle 5; a following read of 0x40 returns 0x0000AB00 with word 0x10 cleared beforehand.
- Out of range: read of addr 0x0010_0000 -> `sram_cs_o` never asserted; ready in cycle 2 with rdata 0 and err 1.
- Reset mid-access: `rst_n` driven low during WAIT of a write -> no ready pulse; SRAM content unchanged; next request after reset completes normally.
- Posted write (`DMEM_POSTED_WRITE_EN`):
  - stimulus: write 0x12345678 to 0x80 at W=0, immediately followed by a read of 0x80;
  - response: ready in cycle 0 for the write; the read is accepted in cycle 2 and returns 0x12345678 in cycle 4.
- Back-to-back: 100 random reads and writes, each with `valid` raised the cycle after the previous ready -> results match a reference memory model; exactly one ready pulse per request.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StResp
    } dmem_state_t;

    localparam int unsigned DMEM_WORD_BYTES = 4;
    localparam int unsigned DMEM_MAX_WAIT   = 15;

endpackage

// File: rtl/dmem_wait_cnt.sv
// Loadable 4-bit down-counter; zero_o flags the last wait cycle.
module dmem_wait_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/dmem_ctrl.sv
// LSU-to-SRAM data-memory controller with optional wait states.
// Define DMEM_POSTED_WRITE_EN to acknowledge writes at acceptance and drain them afterwards.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH_WORDS = 262144,
    parameter int unsigned WAIT_STATES     = 0,
    parameter int unsigned AW              = $clog2(MEM_DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dmem_valid_i,
    output logic          dmem_ready_o,
    input  logic [31:0]   dmem_addr_i,
    input  logic [31:0]   dmem_wdata_i,
    input  logic [3:0]    dmem_we_i,
    output logic [31:0]   dmem_rdata_o,
    output logic          dmem_err_o,
    output logic          sram_cs_o,
    output logic [3:0]    sram_we_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [31:0]   sram_wdata_o,
    input  logic [31:0]   sram_rdata_i
);

    localparam int unsigned LSB      = $clog2(DMEM_WORD_BYTES);
    localparam int unsigned WAIT_EFF = (WAIT_STATES > DMEM_MAX_WAIT) ? DMEM_MAX_WAIT : WAIT_STATES;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_EFF > 0) ? 4'(WAIT_EFF - 1) : 4'd0;

    dmem_state_t   state_q;
    logic [AW-1:0] waddr_q;
    logic [3:0]    we_q;
    logic [31:0]   wdata_q;
    logic          oor_q;
    logic          posted_q;
    logic          rd_ok_q;
    logic          ready_q;
    logic          err_q;
    logic          cs_q;
    logic [3:0]    sram_we_q;

    logic          accept;
    logic          req_oor;
    logic          post_ack;
    logic          wait_zero;
    logic [31:0]   addr_hi;
    logic          unused_addr_lsb;

    assign accept          = (state_q == StIdle) && dmem_valid_i;
    assign addr_hi         = dmem_addr_i >> (AW + LSB);
    assign req_oor         = (addr_hi != 32'd0);
    assign unused_addr_lsb = ^dmem_addr_i[LSB-1:0];

`ifdef DMEM_POSTED_WRITE_EN
    assign post_ack = accept && (dmem_we_i != 4'b0000);
`else
    assign post_ack = 1'b0;
`endif

    dmem_wait_cnt u_wait_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (WAIT_LOAD),
        .dec_i      (state_q == StWait),
        .zero_o     (wait_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            waddr_q   <= '0;
            we_q      <= 4'b0000;
            wdata_q   <= 32'd0;
            oor_q     <= 1'b0;
            posted_q  <= 1'b0;
            rd_ok_q   <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            cs_q      <= 1'b0;
            sram_we_q <= 4'b0000;
        end else begin
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            cs_q      <= 1'b0;
            sram_we_q <= 4'b0000;
            case (state_q)
                StIdle: begin
                    if (dmem_valid_i) begin
                        waddr_q  <= dmem_addr_i[AW+LSB-1:LSB];
                        we_q     <= dmem_we_i;
                        wdata_q  <= dmem_wdata_i;
                        oor_q    <= req_oor;
                        posted_q <= post_ack;
                        if (WAIT_EFF > 0) begin
                            state_q <= StWait;
                        end else begin
                            // Out-of-range requests never select the SRAM.
                            state_q   <= StAccess;
                            cs_q      <= !req_oor;
                            sram_we_q <= req_oor ? 4'b0000 : dmem_we_i;
                        end
                    end
                end
                StWait: begin
                    if (wait_zero) begin
                        state_q   <= StAccess;
                        cs_q      <= !oor_q;
                        sram_we_q <= oor_q ? 4'b0000 : we_q;
                    end
                end
                StAccess: begin
                    if (posted_q) begin
                        state_q <= StIdle;
                    end else begin
                        state_q <= StResp;
                        ready_q <= 1'b1;
                        err_q   <= oor_q;
                        rd_ok_q <= (we_q == 4'b0000) && !oor_q;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Posted writes complete combinationally at acceptance.
    assign dmem_ready_o = ready_q | post_ack;
    assign dmem_err_o   = err_q | (post_ack & req_oor);
    assign dmem_rdata_o = (ready_q && rd_ok_q) ? sram_rdata_i : 32'd0;
    assign sram_cs_o    = cs_q;
    assign sram_we_o    = sram_we_q;
    assign sram_addr_o  = waddr_q;
    assign sram_wdata_o = wdata_q;

endmodule
